seg7_multi_display: RTL and testbench

Parametrised multi-digit seven-segment display controller, the successor to the single-digit combinational hex decoder. It latches a packed nibble word on a load strobe and drives DIGITS active-low HEX outputs. It adds optional leading-zero blanking, a blink mode and a marquee scroll mode, all timed from CLOCK_50 by internal dividers. It sits between user logic or the board switches and the board's HEX displays.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_multi_display_if.sv | 14 +
 rtl/seg7_glyph.sv | 31 +++
 rtl/seg7_multi_display.sv | 135 +++++++++++++
 tb/tb_seg7_multi_display.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the multi-digit seven-segment controller.
// Segment vectors are active-low, bit order g..a.
package seg7_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_SCROLL = 2'b10,
        MODE_BLANK  = 2'b11
    } mode_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_I     = 7'b1111001;
    localparam logic [6:0] SEG_Y     = 7'b0010001;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_multi_display_if.sv
// User-side bus of the display controller: load strobe, nibble word, mode controls and
// the registered segment outputs.
interface seg7_multi_display_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  LOAD;
    logic [4*DIGITS-1:0]   DATA;
    logic [1:0]            MODE;
    logic                  LZ_EN;
    logic [7*DIGITS-1:0]   HEX;

    modport master (output LOAD, DATA, MODE, LZ_EN, input HEX);
    modport slave  (input LOAD, DATA, MODE, LZ_EN, output HEX);
endinterface

// File: rtl/seg7_glyph.sv
// Combinational nibble to active-low segment decoder (0-9, C, U, I, Y, H, blank).
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        unique case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_C;
            4'hB: o_seg = SEG_U;
            4'hC: o_seg = SEG_I;
            4'hD: o_seg = SEG_Y;
            4'hE: o_seg = SEG_H;
            4'hF: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_multi_display.sv
// Multi-digit seven-segment controller: latched nibble word, leading-zero blanking,
// blink and marquee scroll modes timed by internal dividers; HEX fully registered.
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned BLINK_DIV  = 25_000_000,
    parameter int unsigned SCROLL_DIV = 12_500_000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    seg7_multi_display_if.slave  bus
);

    localparam int unsigned SLOTS = 2 * DIGITS;
    localparam int unsigned BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned SW    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int unsigned OW    = $clog2(SLOTS);

    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_DIV - 1);
    localparam logic [OW-1:0] OFF_LAST    = OW'(SLOTS - 1);

    logic [4*DIGITS-1:0] r_data;
    mode_e               r_mode;
    logic [BW-1:0]       r_blink_div, w_blink_div_d;
    logic [SW-1:0]       r_scroll_div, w_scroll_div_d;
    logic                r_phase_on, w_phase_on_d;
    logic [OW-1:0]       r_off, w_off_d;
    logic [7*DIGITS-1:0] r_hex, w_hex_d;

    logic                w_restart;
    logic [DIGITS-1:0]   w_suppress;
    logic [3:0]          w_s_nib [SLOTS];
    logic [6:0]          w_s_seg [SLOTS];

    assign w_restart = bus.LOAD | (bus.MODE != r_mode);

    // A display is suppressed while every nibble from the top down to it is zero.
    always_comb begin
        logic lead;
        lead       = 1'b1;
        w_suppress = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead          = lead & (r_data[4*i +: 4] == 4'h0);
            w_suppress[i] = bus.LZ_EN & lead;
        end
    end

    // S[p] for p < DIGITS is display DIGITS-1-p; the trailing half is blank (nibble F).
    for (genvar p = 0; p < SLOTS; p++) begin : g_slot
        if (p < DIGITS) begin : g_digit
            assign w_s_nib[p] = w_suppress[DIGITS-1-p] ? 4'hF : r_data[4*(DIGITS-1-p) +: 4];
        end else begin : g_pad
            assign w_s_nib[p] = 4'hF;
        end
        seg7_glyph u_glyph (
            .i_nibble (w_s_nib[p]),
            .o_seg    (w_s_seg[p])
        );
    end

    always_comb begin
        w_blink_div_d  = '0;
        w_scroll_div_d = '0;
        w_phase_on_d   = r_phase_on;
        w_off_d        = r_off;
        if (w_restart) begin
            w_phase_on_d = 1'b1;
            w_off_d      = '0;
        end else begin
            if (r_mode == MODE_BLINK) begin
                if (r_blink_div == BLINK_LAST) begin
                    w_phase_on_d = ~r_phase_on;
                end else begin
                    w_blink_div_d = r_blink_div + 1'b1;
                end
            end
            if (r_mode == MODE_SCROLL) begin
                if (r_scroll_div == SCROLL_LAST) begin
                    w_off_d = (r_off == OFF_LAST) ? '0 : r_off + 1'b1;
                end else begin
                    w_scroll_div_d = r_scroll_div + 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [OW:0] idx;
        idx     = '0;
        w_hex_d = '1;
        unique case (r_mode)
            MODE_STATIC: begin
                for (int i = 0; i < DIGITS; i++) w_hex_d[7*i +: 7] = w_s_seg[DIGITS-1-i];
            end
            MODE_BLINK: begin
                if (r_phase_on) begin
                    for (int i = 0; i < DIGITS; i++) w_hex_d[7*i +: 7] = w_s_seg[DIGITS-1-i];
                end
            end
            MODE_SCROLL: begin
                for (int k = 0; k < DIGITS; k++) begin
                    idx = {1'b0, r_off} + (OW+1)'(k);
                    if (idx >= (OW+1)'(SLOTS)) idx = idx - (OW+1)'(SLOTS);
                    w_hex_d[7*(DIGITS-1-k) +: 7] = w_s_seg[idx[OW-1:0]];
                end
            end
            MODE_BLANK: w_hex_d = '1;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_data       <= '0;
            r_mode       <= MODE_STATIC;
            r_blink_div  <= '0;
            r_scroll_div <= '0;
            r_phase_on   <= 1'b1;
            r_off        <= '0;
            r_hex        <= '1;
        end else begin
            if (bus.LOAD) r_data <= bus.DATA;
            r_mode       <= mode_e'(bus.MODE);
            r_blink_div  <= w_blink_div_d;
            r_scroll_div <= w_scroll_div_d;
            r_phase_on   <= w_phase_on_d;
            r_off        <= w_off_d;
            r_hex        <= w_hex_d;
        end
    end

    assign bus.HEX = r_hex;

endmodule

// File: tb/tb_seg7_multi_display.sv
// Directed bench for seg7_multi_display with DIGITS=4, BLINK_DIV=4, SCROLL_DIV=3.
module tb_seg7_multi_display;

    localparam logic [6:0]  BL  = 7'h7F;
    localparam logic [27:0] ALL = 28'hFFFFFFF;

    typedef struct {
        string       name;
        logic [15:0] data;
        logic [1:0]  mode;
        logic        lz;
        logic [27:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seg7_multi_display_if #(.DIGITS(4)) bus ();

    seg7_multi_display #(
        .DIGITS     (4),
        .BLINK_DIV  (4),
        .SCROLL_DIV (3)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h46, 7'h41, 7'h79, 7'h11, 7'h09, 7'h7F};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: HEX=%h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ch2seg(input byte c);
        return (c == "_") ? BL : gl[c - "0"];
    endfunction

    function automatic logic [27:0] win2hex(input string w);
        return {ch2seg(w[0]), ch2seg(w[1]), ch2seg(w[2]), ch2seg(w[3])};
    endfunction

    vec_t        vecs[$];
    vec_t        v;
    string       wins[9];
    logic [27:0] img, img2, zimg;

    initial begin
        bus.LOAD  = 1'b0;
        bus.DATA  = '0;
        bus.MODE  = 2'b00;
        bus.LZ_EN = 1'b1;

        vecs.push_back('{"lz_0c05",   16'h0C05, 2'b00, 1'b1, {BL, 7'h79, 7'h40, 7'h12}});
        vecs.push_back('{"nolz_0c05", 16'h0C05, 2'b00, 1'b0, {7'h40, 7'h79, 7'h40, 7'h12}});
        vecs.push_back('{"lz_0010",   16'h0010, 2'b00, 1'b1, {BL, BL, 7'h79, 7'h40}});
        vecs.push_back('{"lz_zero",   16'h0000, 2'b00, 1'b1, {BL, BL, BL, 7'h40}});
        vecs.push_back('{"lz_0a00",   16'h0A00, 2'b00, 1'b1, {BL, 7'h46, 7'h40, 7'h40}});
        for (int n = 0; n < 16; n++) begin
            v.name = $sformatf("glyph_%0h", n);
            v.data = 16'(n);
            v.mode = 2'b00;
            v.lz   = 1'b0;
            v.exp  = {7'h40, 7'h40, 7'h40, gl[n]};
            vecs.push_back(v);
        end
        vecs.push_back('{"blank_mode", 16'h1234, 2'b11, 1'b0, ALL});
        vecs.push_back('{"blank_lz",   16'h0C05, 2'b11, 1'b1, ALL});

        // Asynchronous reset before any clock edge has been seen.
        #2 rst_n = 1'b0;
        #1 chk("reset_async", bus.HEX, ALL);
        repeat (2) @(negedge clk);
        chk("reset_hold", bus.HEX, ALL);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_first_edge", bus.HEX, {BL, BL, BL, 7'h40});

        foreach (vecs[i]) begin
            bus.LOAD  = 1'b1;
            bus.DATA  = vecs[i].data;
            bus.MODE  = vecs[i].mode;
            bus.LZ_EN = vecs[i].lz;
            @(negedge clk);
            bus.LOAD = 1'b0;
            @(negedge clk);
            chk(vecs[i].name, bus.HEX, vecs[i].exp);
        end

        // Blink: 4 on, 4 off from the restart; reload during an off phase.
        img       = {7'h79, 7'h24, 7'h30, 7'h19};
        img2      = {7'h00, 7'h19, 7'h24, 7'h79};
        bus.LZ_EN = 1'b1;
        bus.MODE  = 2'b01;
        bus.DATA  = 16'h1234;
        bus.LOAD  = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            chk($sformatf("blink_%0d", j), bus.HEX, (((j - 1) / 4) % 2 == 0) ? img : ALL);
        end
        bus.DATA = 16'h8421;
        bus.LOAD = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
        chk("blink_reload_gap", bus.HEX, ALL);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            chk($sformatf("blink_reload_%0d", j), bus.HEX, (j <= 4) ? img2 : ALL);
        end

        // Scroll: nine 3-cycle windows, ending back on the static image.
        wins = '{"1234", "234_", "34__", "4___", "____", "___1", "__12", "_123", "1234"};
        bus.MODE = 2'b10;
        bus.DATA = 16'h1234;
        bus.LOAD = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
        for (int w = 0; w < 9; w++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk($sformatf("scroll_w%0d_c%0d", w, c), bus.HEX, win2hex(wins[w]));
            end
        end

        // Reset mid-scroll at off=5, asserted between edges.
        bus.LOAD = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
        repeat (16) @(negedge clk);
        chk("midscroll_off5", bus.HEX, win2hex("___1"));
        rst_n = 1'b0;
        #1 chk("midscroll_reset_async", bus.HEX, ALL);
        @(negedge clk);
        chk("midscroll_reset_hold", bus.HEX, ALL);
        rst_n = 1'b1;
        zimg  = {BL, BL, BL, 7'h40};
        @(negedge clk);
        chk("after_reset_e1", bus.HEX, zimg);
        repeat (3) @(negedge clk);
        chk("after_reset_off0", bus.HEX, zimg);
        @(negedge clk);
        chk("after_reset_off1", bus.HEX, {BL, BL, 7'h40, BL});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
